// File: rtl/defuse_puzzle_core_if.sv
// Handshake/status bundle between the defuse puzzle core and its user.
// The master side drives the player inputs; the slave side is the core.
interface defuse_puzzle_core_if #(
  parameter int N_SCREENS = 4,
  parameter int SYM_W     = 2,
  parameter int PERIOD_W  = 8
);
  // rand_req is the deal request ("rand" is a reserved word in SystemVerilog)
  logic                       rand_req;
  logic                       set;
  logic [N_SCREENS-1:0]       switch;
  logic                       enable;
  logic [2:0]                 check;
  logic [PERIOD_W-1:0]        period;
  logic [N_SCREENS*SYM_W-1:0] screens;
  logic [SYM_W-1:0]           main;
  logic [2:0]                 strikes;

  modport master (
    output rand_req, set, switch, enable,
    input  check, period, screens, main, strikes
  );

  modport slave (
    input  rand_req, set, switch, enable,
    output check, period, screens, main, strikes
  );
endinterface

// File: rtl/defuse_puzzle_core.sv
// Defuse puzzle game core: deals a random puzzle from a free-running Galois LFSR,
// runs a countdown and scores switch-bank answers with a strike limit.
module defuse_puzzle_core #(
  parameter int                   N_SCREENS   = 4,
  parameter int                   SYM_W       = 2,
  parameter int                   LFSR_W      = 16,
  parameter logic [LFSR_W-1:0]    LFSR_TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0]    SEED        = 16'hACE1,
  parameter int                   PERIOD_W    = 8,
  parameter logic [PERIOD_W-1:0]  PERIOD_INIT = 8'd200,
  parameter int                   TICK_DIV    = 1000,
  parameter logic [PERIOD_W-1:0]  PENALTY     = 8'd20,
  parameter int                   MAX_STRIKES = 3
) (
  input logic                   clk,
  input logic                   rst,
  defuse_puzzle_core_if.slave   bus
);

  localparam int IDX_W = $clog2(N_SCREENS);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCR_W = N_SCREENS * SYM_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEAL     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_DEFUSED  = 3'd3,
    ST_EXPLODED = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [LFSR_W-1:0]     lfsr_r;
  logic [LFSR_W-1:0]     lfsr_s;
  logic                  rand_r;
  logic                  set_r;
  logic                  rand_edge_s;
  logic                  score_s;
  logic                  timeout_s;
  logic                  answer_ok_s;
  logic                  wrong_s;
  logic                  tick_wrap_s;
  logic [CNT_W-1:0]      tick_r;
  logic [CNT_W-1:0]      tick_s;
  logic [PERIOD_W-1:0]   period_r;
  logic [PERIOD_W-1:0]   period_s;
  logic [PERIOD_W-1:0]   period_dec_s;
  logic [SCR_W-1:0]      screens_r;
  logic [SCR_W-1:0]      screens_s;
  logic [SCR_W-1:0]      deal_screens_s;
  logic [SYM_W-1:0]      main_r;
  logic [SYM_W-1:0]      main_s;
  logic [SYM_W-1:0]      deal_main_s;
  logic [IDX_W-1:0]      deal_idx_s;
  logic [2:0]            strikes_r;
  logic [2:0]            strikes_s;
  logic [2:0]            strikes_inc_s;
  logic [2:0]            check_r;
  logic [2:0]            check_s;
  logic [N_SCREENS-1:0]  match_mask_s;

  // Galois step; the all-zero lock-up state recovers to SEED
  always_comb begin
    lfsr_s = lfsr_r;
    if (lfsr_r == {LFSR_W{1'b0}}) begin
      lfsr_s = SEED;
    end else if (lfsr_r[0]) begin
      lfsr_s = (lfsr_r >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr_s = lfsr_r >> 1;
    end
  end

  // free-running LFSR and input edge-detect registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= SEED;
      rand_r <= 1'b0;
      set_r  <= 1'b0;
    end else begin
      lfsr_r <= lfsr_s;
      rand_r <= bus.rand_req;
      set_r  <= bus.set;
    end
  end

  assign rand_edge_s   = bus.rand_req & ~rand_r;
  assign score_s       = bus.set & ~set_r & bus.enable;
  assign timeout_s     = (period_r == {PERIOD_W{1'b0}});
  assign tick_wrap_s   = bus.enable && (tick_r == CNT_W'(TICK_DIV - 1));
  assign strikes_inc_s = strikes_r + 3'd1;
  assign answer_ok_s   = (bus.switch == match_mask_s);
  assign wrong_s       = (state_r == ST_ARMED) & score_s & ~timeout_s & ~answer_ok_s;

  assign deal_main_s = lfsr_r[LFSR_W-1 -: SYM_W];
  assign deal_idx_s  = lfsr_r[LFSR_W-SYM_W-1 -: IDX_W];

  // puzzle deal with the indexed screen forced to the main symbol, plus match mask
  always_comb begin
    deal_screens_s = {SCR_W{1'b0}};
    match_mask_s   = {N_SCREENS{1'b0}};
    for (int i = 0; i < N_SCREENS; i++) begin
      if (deal_idx_s == IDX_W'(i)) begin
        deal_screens_s[i*SYM_W +: SYM_W] = deal_main_s;
      end else begin
        deal_screens_s[i*SYM_W +: SYM_W] = lfsr_r[i*SYM_W +: SYM_W];
      end
      match_mask_s[i] = (screens_r[i*SYM_W +: SYM_W] == main_r);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: timeout outranks a same-cycle answer
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DEFUSED, ST_EXPLODED: begin
        if (rand_edge_s) begin
          state_s = ST_DEAL;
        end else begin
          state_s = state_r;
        end
      end
      ST_DEAL: state_s = ST_ARMED;
      ST_ARMED: begin
        if (timeout_s) begin
          state_s = ST_EXPLODED;
        end else if (score_s && answer_ok_s) begin
          state_s = ST_DEFUSED;
        end else if (wrong_s && (strikes_inc_s == 3'(MAX_STRIKES))) begin
          state_s = ST_EXPLODED;
        end else begin
          state_s = ST_ARMED;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so check lines up with it
  always_comb begin
    check_s = 3'b000;
    case (state_s)
      ST_ARMED:    check_s = 3'b001;
      ST_DEFUSED:  check_s = 3'b010;
      ST_EXPLODED: check_s = 3'b100;
      default:     check_s = 3'b000;
    endcase
  end

  // round datapath next values
  always_comb begin
    tick_s       = tick_r;
    period_s     = period_r;
    period_dec_s = period_r;
    strikes_s    = strikes_r;
    screens_s    = screens_r;
    main_s       = main_r;
    case (state_r)
      ST_DEAL: begin
        screens_s = deal_screens_s;
        main_s    = deal_main_s;
        period_s  = PERIOD_INIT;
        strikes_s = 3'd0;
        tick_s    = {CNT_W{1'b0}};
      end
      ST_ARMED: begin
        if (!timeout_s) begin
          if (tick_wrap_s) begin
            tick_s       = {CNT_W{1'b0}};
            period_dec_s = period_r - PERIOD_W'(1);
          end else if (bus.enable) begin
            tick_s       = tick_r + CNT_W'(1);
            period_dec_s = period_r;
          end else begin
            tick_s       = tick_r;
            period_dec_s = period_r;
          end
          if (wrong_s) begin
            strikes_s = strikes_inc_s;
            period_s  = (period_dec_s >= PENALTY) ? (period_dec_s - PENALTY)
                                                  : {PERIOD_W{1'b0}};
          end else begin
            period_s = period_dec_s;
          end
        end else begin
          period_s = period_r;
        end
      end
      default: begin
        period_s = period_r;
      end
    endcase
  end

  // registered round outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      check_r   <= 3'b000;
      tick_r    <= {CNT_W{1'b0}};
      period_r  <= {PERIOD_W{1'b0}};
      screens_r <= {SCR_W{1'b0}};
      main_r    <= {SYM_W{1'b0}};
      strikes_r <= 3'd0;
    end else begin
      check_r   <= check_s;
      tick_r    <= tick_s;
      period_r  <= period_s;
      screens_r <= screens_s;
      main_r    <= main_s;
      strikes_r <= strikes_s;
    end
  end

  assign bus.check   = check_r;
  assign bus.period  = period_r;
  assign bus.screens = screens_r;
  assign bus.main    = main_r;
  assign bus.strikes = strikes_r;

endmodule

// File: tb/tb_defuse_puzzle_core.sv
// Directed bench for defuse_puzzle_core with a small reference LFSR model
// predicting every dealt puzzle.
module tb_defuse_puzzle_core;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_bad;
  int   n_wait;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;
  logic [7:0]  exp_scr;
  logic [1:0]  exp_main;
  logic [3:0]  exp_mask;

  defuse_puzzle_core_if #(.N_SCREENS(4), .SYM_W(2), .PERIOD_W(8)) bus ();

  defuse_puzzle_core #(
    .N_SCREENS(4), .SYM_W(2), .LFSR_W(16), .LFSR_TAPS(TAPS), .SEED(SEED),
    .PERIOD_W(8), .PERIOD_INIT(8'd10), .TICK_DIV(4), .PENALTY(8'd3),
    .MAX_STRIKES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // reference LFSR; m_prev is the value the core sampled at the last edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= SEED;
      m_prev <= 16'h0000;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // predicted deal from the LFSR value sampled in the DEAL cycle
  task automatic predict(input logic [15:0] v);
    logic [1:0] idx;
    exp_scr  = v[7:0];
    exp_main = v[15:14];
    idx      = v[13:12];
    exp_scr[idx*2 +: 2] = exp_main;
    for (int i = 0; i < 4; i++) exp_mask[i] = (exp_scr[i*2 +: 2] == exp_main);
  endtask

  task automatic deal(input string tag);
    bus.rand_req = 1'b1;
    step(1);
    bus.rand_req = 1'b0;
    step(1);
    predict(m_prev);
    check_val({tag, "_check"},   32'(bus.check),   32'd1);
    check_val({tag, "_period"},  32'(bus.period),  32'd10);
    check_val({tag, "_strikes"}, 32'(bus.strikes), 32'd0);
    check_val({tag, "_screens"}, 32'(bus.screens), 32'(exp_scr));
    check_val({tag, "_main"},    32'(bus.main),    32'(exp_main));
  endtask

  initial begin
    logic [3:0] obs_mask;
    n_checks     = 0;
    n_bad        = 0;
    clk          = 1'b0;
    rst          = 1'b1;
    bus.rand_req = 1'b0;
    bus.set      = 1'b0;
    bus.switch   = 4'b0000;
    bus.enable   = 1'b0;

    // 1. reset and idle, then first deal
    step(2);
    rst = 1'b0;
    step(10);
    check_val("idle_check",   32'(bus.check),   32'd0);
    check_val("idle_period",  32'(bus.period),  32'd0);
    check_val("idle_strikes", 32'(bus.strikes), 32'd0);
    check_val("idle_screens", 32'(bus.screens), 32'd0);
    deal("deal1");
    for (int i = 0; i < 4; i++) obs_mask[i] = (bus.screens[i*2 +: 2] == bus.main);
    check_val("deal1_anymatch", 32'(|obs_mask), 32'd1);

    // 2. correct answer defuses and freezes the countdown
    bus.enable = 1'b1;
    bus.switch = exp_mask;
    bus.set    = 1'b1;
    step(1);
    bus.set = 1'b0;
    check_val("defuse_check", 32'(bus.check), 32'd2);
    step(12);
    check_val("defuse_period_frozen", 32'(bus.period), 32'd10);
    check_val("defuse_check_hold",    32'(bus.check),  32'd2);

    // 3. three wrong answers; enable only open during each submit cycle
    bus.enable = 1'b0;
    deal("deal2");
    bus.switch = ~exp_mask;
    for (int k = 1; k <= 3; k++) begin
      bus.enable = 1'b1;
      bus.set    = 1'b1;
      step(1);
      bus.set    = 1'b0;
      bus.enable = 1'b0;
      check_val($sformatf("wrong%0d_strikes", k), 32'(bus.strikes), 32'(k));
      check_val($sformatf("wrong%0d_period", k),  32'(bus.period),  32'(10 - 3 * k));
      check_val($sformatf("wrong%0d_check", k),   32'(bus.check),   (k == 3) ? 32'd4 : 32'd1);
      step(1);
    end
    step(5);
    check_val("exploded_hold_strikes", 32'(bus.strikes), 32'd3);

    // 4. countdown timing with a pause
    deal("deal3");
    bus.enable = 1'b1;
    step(4);
    check_val("tick_first_step", 32'(bus.period), 32'd9);
    bus.enable = 1'b0;
    step(20);
    check_val("pause_hold", 32'(bus.period), 32'd9);
    bus.enable = 1'b1;
    n_wait = 0;
    while (n_wait < 100 && bus.check != 3'b100) begin
      step(1);
      n_wait++;
    end
    check_val("timeout_cycles", 32'(n_wait),       32'd37);
    check_val("timeout_period", 32'(bus.period),   32'd0);
    check_val("timeout_check",  32'(bus.check),    32'd4);

    // 5. set with enable low is dropped; rand while armed is ignored
    bus.enable = 1'b0;
    deal("deal4");
    bus.switch = ~exp_mask;
    bus.set    = 1'b1;
    step(1);
    bus.set = 1'b0;
    step(1);
    check_val("set_disabled_strikes", 32'(bus.strikes), 32'd0);
    check_val("set_disabled_check",   32'(bus.check),   32'd1);
    bus.rand_req = 1'b1;
    step(1);
    bus.rand_req = 1'b0;
    step(2);
    check_val("rand_armed_screens", 32'(bus.screens), 32'(exp_scr));
    check_val("rand_armed_check",   32'(bus.check),   32'd1);

    // 6. asynchronous reset mid-round, then deal again from SEED
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_check",   32'(bus.check),   32'd0);
    check_val("async_rst_period",  32'(bus.period),  32'd0);
    check_val("async_rst_screens", 32'(bus.screens), 32'd0);
    check_val("async_rst_main",    32'(bus.main),    32'd0);
    check_val("async_rst_strikes", 32'(bus.strikes), 32'd0);
    step(1);
    rst = 1'b0;
    step(3);
    check_val("post_rst_check", 32'(bus.check), 32'd0);
    deal("deal5");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
